dom_and_pipe: RTL and testbench
===============================

DOM_AND_PIPE -- requirements
Module: dom_and_pipe

Interface
REQ-001 SHALL have parameter ORDER, default 1, masking order d; share count N = ORDER+1.
REQ-002 SHALL have parameter WIDTH, default 1, number of independent bitsliced AND lanes.
REQ-003 SHALL have derived local parameter RBITS = WIDTH*N*(N-1)/2, fresh random bits per accepted input.
REQ-004 SHALL have port clock_0  input  1  sole clock; all registers sample on its rising edge.
REQ-005 SHALL have port reset_0  input  1  synchronous, active-high reset.
REQ-006 SHALL have port io_in_valid  input  1  input shares and p_rand are valid this cycle.
REQ-007 SHALL have port io_in_ready  output  1  gadget accepts input this cycle.
REQ-008 SHALL have port io_i0  input  WIDTH*N  shares of operand a; lane w share s at bit s*WIDTH+w.
REQ-009 SHALL have port io_i1  input  WIDTH*N  shares of operand b; same layout as io_i0.
REQ-010 SHALL have port p_rand  input  RBITS  fresh randomness; pair k, lane w at bit k*WIDTH+w.
REQ-011 SHALL have port io_out_valid  output  1  io_o0 holds a valid result.
REQ-012 SHALL have port io_out_ready  input  1  downstream consumes the result this cycle.
REQ-013 SHALL have port io_o0  output  WIDTH*N  shares of c = a AND b; same layout as io_i0.

Function
REQ-014 SHALL enumerate share pairs (i,j), i<j, lexicographically as k = 0,1,...; for ORDER=1 the only pair is (0,1), k=0; the pair's random bit is z_ij = z_ji.
REQ-015 SHALL compute, per lane, stage-1 terms: inner t_ii = a_i&b_i; cross t_ij = (a_i&b_j) XOR z_ij for every j != i.
REQ-016 SHALL register every stage-1 term individually, with no XOR of distinct terms before the register, to stop glitch propagation.
REQ-017 SHALL compute stage 2 as c_i = XOR over j of registered t_ij, and register it into io_o0.
REQ-018 SHALL have io_o0 driven only from stage-2 registers, with no combinational path from inputs.
REQ-019 SHALL have latency of exactly 2 cycles from input acceptance to io_out_valid=1 when not stalled.
REQ-020 SHALL accept input on cycles with io_in_valid & io_in_ready; p_rand is consumed only on such cycles.
REQ-021 SHALL implement a 2-entry pipeline with per-stage valid bits v1, v2; io_out_valid = v2.
REQ-022 SHALL let stage 2 load when !v2 | io_out_ready.
REQ-023 SHALL let stage 1 load when !v1 | stage-2 load.
REQ-024 SHALL set io_in_ready = stage-1 load enable, a combinational function of v1, v2 and io_out_ready only.
REQ-025 SHALL sustain one result per cycle with io_out_ready held at 1.
REQ-026 SHALL hold stage-1 and stage-2 data and valid bits unchanged while the corresponding stage is stalled; a held t_ij is never re-masked.
REQ-027 SHALL clear v1 on a cycle where stage 2 loads and no input is accepted; stage-1 data may then keep its old value.
REQ-028 SHALL satisfy XOR of io_o0 shares = (XOR of io_i0 shares) AND (XOR of io_i1 shares) per lane, for the corresponding accepted input.

Reset
REQ-029 SHALL, when reset_0=1 at a clock edge, clear v1, v2, all stage-1 term registers and all io_o0 registers to 0.
REQ-030 SHALL drive io_in_ready=1 and io_out_valid=0 in the cycle after reset.
REQ-031 SHALL let reset_0 mid-operation discard all in-flight data with no output produced, and SHALL ignore io_in_valid during the reset cycle.

Verification
REQ-032 SHALL pass: ORDER=1, WIDTH=1, io_i0 shares (1,0), io_i1 shares (0,1), p_rand=1 -> after 2 cycles io_o0 shares (0,1), XOR=1.
REQ-033 SHALL pass: ORDER=2, WIDTH=4, 10000 random inputs and random p_rand with io_out_ready=1 -> every output unmasks to a&b, results are in order, and one result appears per cycle after 2-cycle fill.
REQ-034 SHALL pass: two inputs accepted back to back, then io_out_ready=0 for 3 cycles -> io_in_ready=0 from the cycle the pipeline is full, io_o0 is stable, and the first result is delivered intact when ready returns.
REQ-035 SHALL pass: p_rand changes every cycle during a stall -> output shares equal those computed with the p_rand sampled at acceptance.
REQ-036 SHALL pass: reset_0 asserted 1 cycle after an accepted input -> io_out_valid stays 0 and io_o0 = 0 until a new input is accepted.
REQ-037 SHALL pass: ORDER=1, WIDTH=1 exhaustive over 16 share patterns with p_rand=0 and p_rand=1 -> all outputs correct, checked for first-order probing security with glitches in the team's verification flow.

Source files
------------

// File: rtl/dom_and_pipe.sv
// ---------------------------------------------------------------------------
// dom_and_pipe
//   Domain-oriented masked (DOM) AND gadget of arbitrary order, WIDTH
//   independent bitsliced lanes, wrapped in a 2-entry valid/ready pipeline.
//
//   Stage 1 registers every inner term t_ii = a_i & b_i and every cross term
//   t_ij = (a_i & b_j) ^ z_ij individually. Stage 2 XORs a share domain's
//   registered terms together and registers the result into io_o0.
//
// Parameters
//   ORDER : masking order d, share count N = ORDER+1 (ORDER >= 1)
//   WIDTH : number of bitsliced AND lanes
//
// Ports
//   clock_0      : clock, rising edge
//   reset_0      : synchronous active-high reset
//   io_in_valid  : io_i0 / io_i1 / p_rand valid this cycle
//   io_in_ready  : gadget accepts input this cycle
//   io_i0, io_i1 : operand shares, lane w of share s at bit s*WIDTH+w
//   p_rand       : fresh randomness, lane w of pair k at bit k*WIDTH+w
//   io_out_valid : io_o0 holds a valid result
//   io_out_ready : downstream consumes the result this cycle
//   io_o0        : shares of a AND b, same layout as io_i0
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. valid never depends on ready; io_in_ready depends only on the
// pipeline valid bits and io_out_ready, never on io_in_valid. Data on a port
// is only meaningful while its valid is 1.
// ---------------------------------------------------------------------------
module dom_and_pipe #(
  parameter  int ORDER = 1,
  parameter  int WIDTH = 1,
  localparam int N     = ORDER + 1,
  localparam int RBITS = WIDTH * N * (N - 1) / 2
) (
  input  logic                 clock_0,
  input  logic                 reset_0,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [WIDTH*N-1:0]   io_i0,
  input  logic [WIDTH*N-1:0]   io_i1,
  input  logic [RBITS-1:0]     p_rand,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [WIDTH*N-1:0]   io_o0
);

  // Lexicographic index of share pair (lo,hi), lo < hi.
  function automatic int pair_idx(input int lo, input int hi);
    return lo * N - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic                              v1_q, v2_q;
  logic                              ld1, ld2, accept;
  logic [N-1:0][N-1:0][WIDTH-1:0]    t_q, t_d;
  logic [WIDTH*N-1:0]                o_q, o_d;

  // Stage 2 frees up when empty or when its result is being consumed;
  // stage 1 frees up when empty or when it can push into stage 2.
  assign ld2          = !v2_q || io_out_ready;
  assign ld1          = !v1_q || ld2;
  assign io_in_ready  = ld1;
  assign accept       = io_in_valid && ld1;
  assign io_out_valid = v2_q;
  assign io_o0        = o_q;

  // Stage-1 terms. z_ij and z_ji share the same random bit.
  always_comb begin
    t_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i == j) begin
          t_d[i][j] = io_i0[i*WIDTH +: WIDTH] & io_i1[i*WIDTH +: WIDTH];
        end else begin
          t_d[i][j] = (io_i0[i*WIDTH +: WIDTH] & io_i1[j*WIDTH +: WIDTH])
                    ^ p_rand[pair_idx((i < j) ? i : j, (i < j) ? j : i)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Stage-2 compression: only registered terms are combined, so glitches
  // from the input side cannot reach the XOR tree.
  always_comb begin
    o_d = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        o_d[i*WIDTH +: WIDTH] = o_d[i*WIDTH +: WIDTH] ^ t_q[i][j];
      end
    end
  end

  always_ff @(posedge clock_0) begin
    if (reset_0) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      t_q  <= '0;
      o_q  <= '0;
    end else begin
      // Output data only moves when a valid term set arrives, so io_o0
      // stays at its last value (or 0 after reset) otherwise.
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) o_q <= o_d;
      end
      // Terms are captured only on acceptance; a stalled term set is never
      // recomputed with newer randomness.
      if (ld1) begin
        v1_q <= accept;
        if (accept) t_q <= t_d;
      end
    end
  end

endmodule

// File: tb/tb_dom_and_pipe.sv
// ---------------------------------------------------------------------------
// tb_dom_and_pipe
//   Two instances: dut_a (ORDER=1, WIDTH=1) and dut_b (ORDER=2, WIDTH=4).
//   Per-instance scoreboards hold expected shares and expected unmasked
//   values pushed at acceptance and compared when a result is consumed.
// ---------------------------------------------------------------------------
module tb_dom_and_pipe;

  localparam int N_A = 2, W_A = 1, R_A = 1;
  localparam int N_B = 3, W_B = 4, R_B = 12;

  // clock / reset
  logic clock_0 = 1'b0;
  always #5 clock_0 = ~clock_0;
  logic reset_0;

  // dut_a signals
  logic                 in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [N_A*W_A-1:0]   i0_a, i1_a, o0_a;
  logic [R_A-1:0]       rand_a;
  // dut_b signals
  logic                 in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [N_B*W_B-1:0]   i0_b, i1_b, o0_b;
  logic [R_B-1:0]       rand_b;

  dom_and_pipe #(.ORDER(1), .WIDTH(1)) dut_a (
    .clock_0(clock_0), .reset_0(reset_0),
    .io_in_valid(in_valid_a), .io_in_ready(in_ready_a),
    .io_i0(i0_a), .io_i1(i1_a), .p_rand(rand_a),
    .io_out_valid(out_valid_a), .io_out_ready(out_ready_a), .io_o0(o0_a)
  );

  dom_and_pipe #(.ORDER(2), .WIDTH(4)) dut_b (
    .clock_0(clock_0), .reset_0(reset_0),
    .io_in_valid(in_valid_b), .io_in_ready(in_ready_b),
    .io_i0(i0_b), .io_i1(i1_b), .p_rand(rand_b),
    .io_out_valid(out_valid_b), .io_out_ready(out_ready_b), .io_o0(o0_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pops_a   = 0;
  int pops_b   = 0;

  logic [N_A*W_A-1:0] exp_a_q[$];
  logic [W_A-1:0]     expu_a_q[$];
  logic [N_B*W_B-1:0] exp_b_q[$];
  logic [W_B-1:0]     expu_b_q[$];

  // ---------------- reference model ----------------
  // Position of pair (lo,hi) found by walking the pairs in order.
  function automatic int pair_pos(input int n, input int lo, input int hi);
    int k;
    int found;
    k = 0;
    found = -1;
    for (int p = 0; p < n; p++) begin
      for (int q = p + 1; q < n; q++) begin
        if (p == lo && q == hi) found = k;
        k++;
      end
    end
    return found;
  endfunction

  function automatic logic [63:0] dom_model(input int n, input int w,
      input logic [63:0] a, input logic [63:0] b, input logic [63:0] r);
    logic [63:0] res;
    logic        c;
    int          k;
    res = '0;
    for (int l = 0; l < w; l++) begin
      for (int i = 0; i < n; i++) begin
        c = a[i*w+l] & b[i*w+l];
        for (int j = 0; j < n; j++) begin
          if (j != i) begin
            k = pair_pos(n, (i < j) ? i : j, (i < j) ? j : i);
            c = c ^ (a[i*w+l] & b[j*w+l]) ^ r[k*w+l];
          end
        end
        res[i*w+l] = c;
      end
    end
    return res;
  endfunction

  function automatic logic [63:0] unmask(input int n, input int w, input logic [63:0] x);
    logic [63:0] res;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    res  = '0;
    for (int i = 0; i < n; i++) res = res ^ ((x >> (i * w)) & mask);
    return res;
  endfunction

  // ---------------- scoreboards ----------------
  logic [63:0]        ma_tmp;
  logic [N_A*W_A-1:0] ma_e;
  logic [W_A-1:0]     ma_u;
  always @(negedge clock_0) begin
    if (reset_0) begin
      exp_a_q.delete();
      expu_a_q.delete();
    end else begin
      if (out_valid_a && out_ready_a) begin
        pops_a++;
        n_checks += 2;
        if (exp_a_q.size() == 0) begin
          $display("FAIL sb_a_unexpected: got o0=%b, expected no output", o0_a);
        end else begin
          ma_e = exp_a_q.pop_front();
          ma_u = expu_a_q.pop_front();
          if (o0_a !== ma_e) $display("FAIL sb_a_shares: got %b, expected %b", o0_a, ma_e);
          else n_pass++;
          ma_tmp = unmask(N_A, W_A, 64'(o0_a));
          if (ma_tmp[W_A-1:0] !== ma_u)
            $display("FAIL sb_a_unmasked: got %b, expected %b", ma_tmp[W_A-1:0], ma_u);
          else n_pass++;
        end
      end
      if (in_valid_a && in_ready_a) begin
        ma_tmp = dom_model(N_A, W_A, 64'(i0_a), 64'(i1_a), 64'(rand_a));
        exp_a_q.push_back(ma_tmp[N_A*W_A-1:0]);
        ma_tmp = unmask(N_A, W_A, 64'(i0_a)) & unmask(N_A, W_A, 64'(i1_a));
        expu_a_q.push_back(ma_tmp[W_A-1:0]);
      end
    end
  end

  logic [63:0]        mb_tmp;
  logic [N_B*W_B-1:0] mb_e;
  logic [W_B-1:0]     mb_u;
  always @(negedge clock_0) begin
    if (reset_0) begin
      exp_b_q.delete();
      expu_b_q.delete();
    end else begin
      if (out_valid_b && out_ready_b) begin
        pops_b++;
        n_checks += 2;
        if (exp_b_q.size() == 0) begin
          $display("FAIL sb_b_unexpected: got o0=%h, expected no output", o0_b);
        end else begin
          mb_e = exp_b_q.pop_front();
          mb_u = expu_b_q.pop_front();
          if (o0_b !== mb_e) $display("FAIL sb_b_shares: got %h, expected %h", o0_b, mb_e);
          else n_pass++;
          mb_tmp = unmask(N_B, W_B, 64'(o0_b));
          if (mb_tmp[W_B-1:0] !== mb_u)
            $display("FAIL sb_b_unmasked: got %h, expected %h", mb_tmp[W_B-1:0], mb_u);
          else n_pass++;
        end
      end
      if (in_valid_b && in_ready_b) begin
        mb_tmp = dom_model(N_B, W_B, 64'(i0_b), 64'(i1_b), 64'(rand_b));
        exp_b_q.push_back(mb_tmp[N_B*W_B-1:0]);
        mb_tmp = unmask(N_B, W_B, 64'(i0_b)) & unmask(N_B, W_B, 64'(i1_b));
        expu_b_q.push_back(mb_tmp[W_B-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock_0);
    #1;
  endtask

  task automatic drive_rand_b();
    i0_b   = 12'($urandom_range(0, 4095));
    i1_b   = 12'($urandom_range(0, 4095));
    rand_b = 12'($urandom_range(0, 4095));
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0) && cnt < 20) begin
      tick();
      cnt++;
    end
    @(negedge clock_0);
    n_checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0)
      $display("FAIL drain_timeout: pending a=%0d b=%0d, expected 0 0", exp_a_q.size(), exp_b_q.size());
    else n_pass++;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_0 = 1'b1;
    in_valid_a = 1'b1; in_valid_b = 1'b1;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    i0_a = '1; i1_a = '1; rand_a = '0;
    drive_rand_b();
    tick();
    tick();
    reset_0 = 1'b0;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    @(negedge clock_0);
    n_checks += 6;
    if (in_ready_a !== 1'b1) $display("FAIL reset_in_ready_a: got %b, expected 1", in_ready_a); else n_pass++;
    if (out_valid_a !== 1'b0) $display("FAIL reset_out_valid_a: got %b, expected 0", out_valid_a); else n_pass++;
    if (o0_a !== '0) $display("FAIL reset_o0_a: got %b, expected 0", o0_a); else n_pass++;
    if (in_ready_b !== 1'b1) $display("FAIL reset_in_ready_b: got %b, expected 1", in_ready_b); else n_pass++;
    if (out_valid_b !== 1'b0) $display("FAIL reset_out_valid_b: got %b, expected 0", out_valid_b); else n_pass++;
    if (o0_b !== '0) $display("FAIL reset_o0_b: got %h, expected 0", o0_b); else n_pass++;
    tick();
  endtask

  // a shares (1,0), b shares (0,1), z=1 -> c shares (0,1)
  task automatic test_directed_o1();
    out_ready_a = 1'b1;
    in_valid_a  = 1'b1;
    i0_a = 2'b01; i1_a = 2'b10; rand_a = 1'b1;
    @(negedge clock_0);
    n_checks++;
    if (in_ready_a !== 1'b1) $display("FAIL dir_accept: got in_ready=%b, expected 1", in_ready_a); else n_pass++;
    tick();
    in_valid_a = 1'b0; i0_a = 2'b11; i1_a = 2'b11; rand_a = 1'b0;
    @(negedge clock_0);
    n_checks++;
    if (out_valid_a !== 1'b0) $display("FAIL dir_latency1: got out_valid=%b, expected 0", out_valid_a); else n_pass++;
    tick();
    @(negedge clock_0);
    n_checks += 3;
    if (out_valid_a !== 1'b1) $display("FAIL dir_latency2: got out_valid=%b, expected 1", out_valid_a); else n_pass++;
    if (o0_a !== 2'b10) $display("FAIL dir_shares: got %b, expected 10", o0_a); else n_pass++;
    if ((o0_a[0] ^ o0_a[1]) !== 1'b1) $display("FAIL dir_unmask: got %b, expected 1", o0_a[0] ^ o0_a[1]); else n_pass++;
    tick();
    drain();
  endtask

  task automatic test_exhaustive_o1();
    int start;
    int miss;
    logic [3:0] pv;
    start = pops_a;
    miss  = 0;
    out_ready_a = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 16; p++) begin
        pv = 4'(p);
        in_valid_a = 1'b1;
        i0_a = pv[1:0]; i1_a = pv[3:2]; rand_a = 1'(r);
        @(negedge clock_0);
        if (!in_ready_a) miss++;
        tick();
      end
    end
    in_valid_a = 1'b0;
    drain();
    n_checks += 2;
    if (miss != 0) $display("FAIL exh_in_ready: got %0d stalled cycles, expected 0", miss); else n_pass++;
    if (pops_a - start != 32) $display("FAIL exh_count: got %0d results, expected 32", pops_a - start); else n_pass++;
  endtask

  task automatic test_random_o2();
    int start;
    int miss;
    int gap;
    start = pops_b;
    miss  = 0;
    gap   = 0;
    out_ready_b = 1'b1;
    for (int t = 0; t < 10002; t++) begin
      in_valid_b = (t < 10000);
      drive_rand_b();
      @(negedge clock_0);
      if (t < 10000 && !in_ready_b) miss++;
      if (t >= 2 && !out_valid_b) gap++;
      tick();
    end
    in_valid_b = 1'b0;
    @(negedge clock_0);
    n_checks += 4;
    if (out_valid_b !== 1'b0) $display("FAIL rnd_tail: got out_valid=%b, expected 0", out_valid_b); else n_pass++;
    if (miss != 0) $display("FAIL rnd_in_ready: got %0d stalled cycles, expected 0", miss); else n_pass++;
    if (gap != 0) $display("FAIL rnd_throughput: got %0d empty cycles, expected 0", gap); else n_pass++;
    if (pops_b - start != 10000) $display("FAIL rnd_count: got %0d results, expected 10000", pops_b - start); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0]        tmp;
    logic [N_B*W_B-1:0] exp_a0;
    out_ready_b = 1'b1;
    in_valid_b  = 1'b1;
    drive_rand_b();
    tmp = dom_model(N_B, W_B, 64'(i0_b), 64'(i1_b), 64'(rand_b));
    exp_a0 = tmp[N_B*W_B-1:0];
    tick();
    drive_rand_b();
    tick();
    // third input offered while the pipeline is full and stalled
    out_ready_b = 1'b0;
    drive_rand_b();
    for (int c = 0; c < 3; c++) begin
      rand_b = 12'($urandom_range(0, 4095));
      @(negedge clock_0);
      n_checks += 3;
      if (in_ready_b !== 1'b0) $display("FAIL b2b_in_ready c%0d: got %b, expected 0", c, in_ready_b); else n_pass++;
      if (out_valid_b !== 1'b1) $display("FAIL b2b_out_valid c%0d: got %b, expected 1", c, out_valid_b); else n_pass++;
      if (o0_b !== exp_a0) $display("FAIL b2b_hold c%0d: got %h, expected %h", c, o0_b, exp_a0); else n_pass++;
      tick();
    end
    out_ready_b = 1'b1;
    @(negedge clock_0);
    n_checks++;
    if (in_ready_b !== 1'b1) $display("FAIL b2b_resume: got in_ready=%b, expected 1", in_ready_b); else n_pass++;
    tick();
    in_valid_b = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready_b = 1'b1;
    in_valid_b  = 1'b1;
    drive_rand_b();
    tick();
    reset_0 = 1'b1;
    drive_rand_b();
    tick();
    reset_0 = 1'b0;
    in_valid_b = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock_0);
      n_checks += 2;
      if (out_valid_b !== 1'b0) $display("FAIL rstmid_valid c%0d: got %b, expected 0", c, out_valid_b); else n_pass++;
      if (o0_b !== '0) $display("FAIL rstmid_o0 c%0d: got %h, expected 0", c, o0_b); else n_pass++;
      tick();
    end
    in_valid_b = 1'b1;
    drive_rand_b();
    tick();
    in_valid_b = 1'b0;
    drain();
  endtask

  initial begin
    reset_0 = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    i0_a = '0; i1_a = '0; rand_a = '0;
    i0_b = '0; i1_b = '0; rand_b = '0;
    test_reset();
    test_directed_o1();
    test_exhaustive_o1();
    test_random_o2();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
